// File: rtl/pc_sequencer_if.sv
// Fetch-stage sequencer bus: control and next-PC inputs plus the registered
// PC/status outputs exchanged between the fetch controller and pc_sequencer.
interface pc_sequencer_if;
  logic        start;
  logic        halt_req;
  logic        stall;
  logic        branch_en;
  logic        call_en;
  logic        ret_en;
  logic [9:0]  target;
  logic [9:0]  npc;
  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] icount;
  logic        stack_err;

  modport master (
    output start, halt_req, stall, branch_en, call_en, ret_en, target, npc,
    input  pc, running, done, icount, stack_err
  );

  modport slave (
    input  start, halt_req, stall, branch_en, call_en, ret_en, target, npc,
    output pc, running, done, icount, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer with run/halt control and a saturating
// retired-instruction counter. Define PC_SEQ_CALL_STACK_EN for the return-address stack.
module pc_sequencer #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [15:0] icount_q, icount_d, icount_inc;
  logic        done_q, done_d;
  logic        err_q, err_d;

  assign icount_inc = (&icount_q) ? icount_q : icount_q + 16'd1;

`ifdef PC_SEQ_CALL_STACK_EN
  localparam int unsigned IdxW = $clog2(STACK_DEPTH);
  localparam int unsigned SpW  = IdxW + 1;
  localparam logic [SpW-1:0] Full = SpW'(STACK_DEPTH);

  logic [9:0]     stack_q [STACK_DEPTH];
  logic [9:0]     stack_d [STACK_DEPTH];
  logic [SpW-1:0] sp_q, sp_d;
  logic [IdxW-1:0] top_idx, push_idx;

  assign top_idx  = IdxW'(sp_q - SpW'(1));
  // A push onto a full stack lands on the current top entry.
  assign push_idx = (sp_q == Full) ? top_idx : IdxW'(sp_q);
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.ret_en, STACK_DEPTH[0]};
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no latches are inferred.
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef PC_SEQ_CALL_STACK_EN
    sp_d    = sp_q;
    stack_d = stack_q;
`endif
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          icount_d = '0;
          err_d    = 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
          sp_d     = '0;
`endif
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d  = ST_HALT;
          done_d   = 1'b1;
          icount_d = icount_inc;
        end else if (!bus.stall) begin
          icount_d = icount_inc;
`ifdef PC_SEQ_CALL_STACK_EN
          if (bus.ret_en) begin
            if (sp_q == '0) begin
              pc_d  = bus.npc;
              err_d = 1'b1;
            end else begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - SpW'(1);
            end
          end else if (bus.call_en) begin
            pc_d              = bus.target;
            stack_d[push_idx] = bus.npc;
            if (sp_q == Full) err_d = 1'b1;
            else              sp_d  = sp_q + SpW'(1);
          end else if (bus.branch_en) begin
            pc_d = bus.target;
          end else begin
            pc_d = bus.npc;
          end
`else
          if (bus.call_en || bus.branch_en) pc_d = bus.target;
          else                              pc_d = bus.npc;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      icount_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
      sp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PC_SEQ_CALL_STACK_EN
      sp_q     <= sp_d;
`endif
    end
  end

`ifdef PC_SEQ_CALL_STACK_EN
  // NOTE: stack storage is not reset; sp_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end
`endif

  assign bus.pc        = pc_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.icount    = icount_q;
  assign bus.stack_err = err_q;

endmodule
